eda_output_streamer: RTL and testbench

- Read-out side of the region-max result matrix.
- On `start` (image processing finished), snapshots the MxN result bit-matrix held by the output RAM into a local buffer.
- Serialises the snapshot row-major as OUT_WIDTH-bit words over a valid/ready stream to the host/DMA side.
- Signals completion with a one-cycle `done` pulse; idles until the next `start`.

---
 rtl/eda_stream_pkg.sv | 16 +
 rtl/eda_row_word_mux.sv | 29 ++
 rtl/eda_output_streamer.sv | 132 +++++++++++++
 tb/tb_eda_output_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eda_stream_pkg.sv
// Shared types and helpers for the region-max result streamer.
package eda_stream_pkg;

    // Streamer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of OUT_WIDTH-bit words needed to carry one N-bit row.
    function automatic int unsigned words_per_row(input int unsigned n, input int unsigned w);
        return (n + w - 1) / w;
    endfunction

endpackage

// File: rtl/eda_row_word_mux.sv
// Selects word k of a result row, zero-padding bits beyond the row width.
module eda_row_word_mux
    import eda_stream_pkg::*;
#(
    parameter int unsigned N         = 10,
    parameter int unsigned OUT_WIDTH = 8,
    localparam int unsigned W        = words_per_row(N, OUT_WIDTH),
    localparam int unsigned SelWidth = $clog2(W) + 1
) (
    input  logic [N-1:0]         row_i,
    input  logic [SelWidth-1:0]  sel_i,
    output logic [OUT_WIDTH-1:0] word_o
);

    logic [W*OUT_WIDTH-1:0] padded;

    // Pad the row to a whole number of words, then pick the selected slice.
    always_comb begin
        padded          = '0;
        padded[N-1:0]   = row_i;
        word_o          = '0;
        for (int k = 0; k < int'(W); k++) begin
            if (sel_i == SelWidth'(k)) begin
                word_o = padded[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

endmodule

// File: rtl/eda_output_streamer.sv
// Snapshots the result bit-matrix on start and streams it row-major as words.
module eda_output_streamer
    import eda_stream_pkg::*;
#(
    parameter int unsigned M          = 4,
    parameter int unsigned N          = 10,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned I_WIDTH    = 2,
    parameter int unsigned WORD_WIDTH = $clog2(words_per_row(N, OUT_WIDTH)) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic [M-1:0][N-1:0]   matrix_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [I_WIDTH-1:0]    out_row,
    output logic                  out_last_in_row,
    output logic                  out_last,
    output logic                  done
);

    localparam int unsigned W        = words_per_row(N, OUT_WIDTH);
    localparam int unsigned SelWidth = $clog2(W) + 1;

    state_e                 state_q, state_d;
    logic [I_WIDTH-1:0]     row_q, row_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic [M-1:0][N-1:0]    snap_q, snap_d;

    logic                   sending;
    logic                   handshake;
    logic                   word_last;
    logic                   row_last;
    logic [N-1:0]           row_vec;
    logic [SelWidth-1:0]    mux_sel;
    logic [OUT_WIDTH-1:0]   mux_word;

    // Decode the current position within the image.
    always_comb begin
        sending   = (state_q == SEND);
        handshake = sending && out_ready;
        word_last = (word_q == WORD_WIDTH'(W - 1));
        row_last  = (row_q == I_WIDTH'(M - 1));
        row_vec   = snap_q[row_q];
        mux_sel   = SelWidth'(word_q);
    end

    eda_row_word_mux #(
        .N         (N),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_row_word_mux (
        .row_i  (row_vec),
        .sel_i  (mux_sel),
        .word_o (mux_word)
    );

    // Next-state: capture, word/row advance, and abort handling.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        word_d  = word_q;
        snap_d  = snap_q;
        if (clear) begin
            // Abort restores the RAM-reset image so a stale snapshot never leaks.
            state_d = IDLE;
            row_d   = '0;
            word_d  = '0;
            snap_d  = '1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_d  = matrix_in;
                        row_d   = '0;
                        word_d  = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (word_last) begin
                            word_d = '0;
                            row_d  = row_q + 1'b1;
                            if (row_last) begin
                                state_d = DONE;
                            end
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and snapshot registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            word_q  <= '0;
            snap_q  <= '1;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            word_q  <= word_d;
            snap_q  <= snap_d;
        end
    end

    // Stream outputs are forced to zero outside SEND so idle reads as reset values.
    always_comb begin
        busy            = sending;
        out_valid       = sending;
        done            = (state_q == DONE);
        out_data        = sending ? mux_word : '0;
        out_row         = sending ? row_q : '0;
        out_last_in_row = sending && word_last;
        out_last        = sending && word_last && row_last;
    end

endmodule

// File: tb/tb_eda_output_streamer.sv
// Randomised scoreboard bench for eda_output_streamer (M=4, N=10, OUT_WIDTH=8).
module tb_eda_output_streamer;

    localparam int M  = 4;
    localparam int N  = 10;
    localparam int OW = 8;
    localparam int IW = 2;
    localparam int WR = (N + OW - 1) / OW;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [IW-1:0] row;
        logic          lir;
        logic          last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 start = 1'b0;
    logic [M-1:0][N-1:0]  matrix_in = '0;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [OW-1:0]        out_data;
    logic [IW-1:0]        out_row;
    logic                 out_last_in_row;
    logic                 out_last;
    logic                 done;

    exp_t q[$];
    logic done_due = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   ready_mode = 0;

    eda_output_streamer #(
        .M         (M),
        .N         (N),
        .OUT_WIDTH (OW),
        .I_WIDTH   (IW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clear           (clear),
        .start           (start),
        .matrix_in       (matrix_in),
        .busy            (busy),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_row         (out_row),
        .out_last_in_row (out_last_in_row),
        .out_last        (out_last),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s got %0h want %0h", name, got, want);
    endtask

    // Ready pattern driver: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
    initial begin
        int rcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            rcnt++;
        end
    end

    // Monitor: the head of the queue must be presented on every valid cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            exp_t e;
            check("done", done, done_due);
            done_due = 1'b0;
            check("busy", busy, q.size() != 0);
            check("out_valid", out_valid, q.size() != 0);
            if (out_valid && q.size() != 0) begin
                e = q[0];
                check("word", {out_data, out_row, out_last_in_row, out_last}, e);
                if (out_ready) begin
                    void'(q.pop_front());
                    if (e.last) done_due = 1'b1;
                end
            end
        end
    end

    // Issue an accepted start; the model snapshots matrix_in at the capture edge.
    task automatic do_start();
        logic [M-1:0][N-1:0] snap;
        exp_t e;
        snap  = matrix_in;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int r = 0; r < M; r++) begin
            for (int k = 0; k < WR; k++) begin
                logic [N-1:0] rv;
                rv     = snap[r];
                e.data = OW'(rv >> (k * OW));
                e.row  = IW'(r);
                e.lir  = (k == WR - 1);
                e.last = (k == WR - 1) && (r == M - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", q.size(), 0);
        q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pattern();
        for (int r = 0; r < M; r++) matrix_in[r] = N'(10'h3FF ^ (10'd1 << r));
    endtask

    initial begin
        // Reset values.
        #2;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_flags", {out_row, out_last_in_row, out_last, done}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic pattern, always ready.
        set_pattern();
        do_start();
        wait_idle();

        // Stalling ready pattern plus snapshot isolation.
        ready_mode = 1;
        set_pattern();
        do_start();
        matrix_in = '0;
        wait_idle();

        // Randomised transfers with spurious starts while busy.
        ready_mode = 2;
        for (int t = 0; t < 12; t++) begin
            for (int r = 0; r < M; r++) matrix_in[r] = N'($urandom);
            do_start();
            for (int c = 0; c < 6; c++) begin
                if (q.size() > 1 && $urandom_range(0, 3) == 0) start = 1'b1;
                matrix_in[$urandom_range(0, M - 1)] = N'($urandom);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            wait_idle();
        end

        // Clear during word 3 aborts without done; restart begins at row 0.
        ready_mode = 0;
        set_pattern();
        do_start();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        clear = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        start = 1'b0;
        q.delete();
        done_due = 1'b0;
        check("clr_valid", out_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        @(posedge clk);
        #1;
        do_start();
        wait_idle();

        // Start in the done cycle is ignored; the following cycle is accepted.
        set_pattern();
        do_start();
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("done_seen", done, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        matrix_in = '1;
        do_start();
        wait_idle();

        // Asynchronous reset mid-transfer.
        ready_mode = 2;
        set_pattern();
        do_start();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        q.delete();
        done_due = 1'b0;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_data", out_data, 0);
        check("arst_flags", {out_row, out_last_in_row, out_last, done}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        matrix_in = '1;
        do_start();
        wait_idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
